dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter AW, default 10, word-address width; the array holds 2**AW 32-bit words.
REQ-002 Parameter WAIT, default 2, number of wait-state cycles between acceptance and response (0..15).
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  initiator request valid.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  32  byte address; sampled with req.
REQ-008 wdata  input  32  write data; sampled with req.
REQ-009 ready  output  1  responder can accept a request this cycle.
REQ-010 rvalid  output  1  response valid.
REQ-011 rdata  output  32  read data; 0 for writes and for errored accesses.
REQ-012 err  output  1  response carries an error; meaningful only while rvalid=1.
REQ-013 rready  input  1  initiator accepts the response.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 ready SHALL equal (state==IDLE); in the other states ready=0 and req is ignored.
REQ-016 A request SHALL be accepted on the rising edge where req=1 and ready=1; addr, we, and wdata SHALL be captured into internal registers at that edge.
REQ-017 On acceptance, the FSM SHALL go IDLE->WAIT and load a 4-bit counter with WAIT-1 when WAIT>0, or go IDLE->RESP directly when WAIT=0.
REQ-018 In WAIT, the counter SHALL decrement once per cycle, and the FSM SHALL move to RESP on the edge where the counter equals 0.
REQ-019 rvalid SHALL be 1 exactly when state==RESP, so the first rvalid cycle follows acceptance by WAIT+1 edges.
REQ-020 The array write (for we=1) and the rdata register load (for we=0) SHALL both occur on the edge that enters RESP.
REQ-021 The array SHALL be indexed by captured addr[AW+1:2].
REQ-022 rdata and err SHALL hold stable while rvalid=1 and rready=0 (back-pressure).
REQ-023 In RESP with rready=1, the FSM SHALL return to IDLE on that edge; the next request cannot be accepted before the following edge (no same-cycle turnaround).
REQ-024 Out of range: if any bit of captured addr[31:AW+2] is nonzero, the response SHALL have err=1 and rdata=0, and the array SHALL be left unmodified.
REQ-025 A read SHALL return the value written by the most recent completed write to that word.
REQ-026 The contents of a never-written word are undefined; the bench SHALL NOT check them.

Reset
REQ-027 While rst_n=0, the block SHALL force state=IDLE, counter=0, rvalid=0, err=0, rdata=0, and ready=1, regardless of clk.
REQ-028 If reset asserts during WAIT, the pending write SHALL be discarded and the array SHALL be unchanged.
REQ-029 If reset asserts during RESP, the response SHALL be dropped.
REQ-030 Reset SHALL NOT clear the array contents.
REQ-031 The first request SHALL be acceptable on the first rising edge after rst_n deasserts.

Configuration
REQ-032 The macro DMEM_RESP_ALIGN_CHECK_EN SHALL control misaligned-address checking.
REQ-033 With DMEM_RESP_ALIGN_CHECK_EN defined, a captured addr[1:0]!=0 SHALL produce err=1 and rdata=0, with no array access; timing SHALL be the same as a normal response.
REQ-034 With DMEM_RESP_ALIGN_CHECK_EN undefined, addr[1:0] SHALL be ignored, the access SHALL proceed to word addr[AW+1:2], and err SHALL reflect the range check only.

Verification
REQ-035 Write then read, WAIT=2: write addr=0x10, wdata=0xDEADBEEF, then read 0x10 -> each rvalid arrives exactly 3 edges after acceptance; read rdata=0xDEADBEEF and err=0.
REQ-036 Back-pressure: read 0x10 with rready held 0 for 5 cycles -> rvalid=1, rdata=0xDEADBEEF, and ready=0 throughout; the return to IDLE occurs on the edge where rready=1.
REQ-037 Range error, AW=10: write addr=0x00001000 with wdata=0x1 -> err=1, rdata=0; a subsequent read of 0x0 returns its prior value.
REQ-038 Alignment: read addr=0x13 -> with DMEM_RESP_ALIGN_CHECK_EN defined, err=1 and rdata=0; with it undefined, err=0 and rdata=word at 0x10.
REQ-039 Reset mid-operation: accept write 0x20 := 0x12345678, then pulse rst_n low during WAIT -> ready=1 and rvalid=0 immediately; a later read of 0x20 returns the old value.
REQ-040 WAIT=0 with back-to-back reads and rready=1 -> rvalid follows each acceptance by 1 edge, and accepted requests occur at most every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Purpose : single-port 2**AW x 32 data-memory responder with a req/ready, rvalid/rready handshake.
// Latency : rvalid rises on the (WAIT+1)th edge counting the acceptance edge; a new request is accepted
//           at the earliest one edge after the response handshake.
// Backpres: ready=0 while a request is in flight; rdata/err hold until rready=1 in RESP.
// Ports   : clk, rst_n (async active-low); req/we/addr/wdata in, ready out (request side);
//           rvalid/rdata/err out, rready in (response side).
// Options : `define DMEM_RESP_ALIGN_CHECK_EN flags addr[1:0]!=0 as an error instead of ignoring it.
module dmem_responder #(
  parameter int AW   = 10,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  input  logic        rready
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [0:(1<<AW)-1];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   eff_addr;
  logic [31:0]   eff_wdata;
  logic          eff_we;
  logic          eff_oor;
  logic          eff_mis;
  logic          eff_err;
  logic [AW-1:0] eff_idx;
  logic          mem_we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    ready  = (state_q == ST_IDLE);
    rvalid = (state_q == ST_RESP);
    accept = req && ready;

    // With WAIT=0 the edge that accepts is also the edge that enters RESP, so the
    // array access must use the live inputs rather than the not-yet-captured copies.
    eff_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    eff_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;
    eff_we    = (state_q == ST_IDLE) ? we    : we_q;
    eff_idx   = eff_addr[AW+1:2];
    eff_oor   = |(eff_addr >> (AW + 2));
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    eff_mis   = |eff_addr[1:0];
`else
    eff_mis   = 1'b0;
`endif
    eff_err   = eff_oor || eff_mis;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = we;
          if (WAIT == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_M1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      err_d   = eff_err;
      rdata_d = (eff_we || eff_err) ? 32'd0 : mem[eff_idx];
    end

    // rst_n gate keeps a WAIT=0 request arriving during reset from touching the array.
    mem_we = enter_resp && eff_we && !eff_err && rst_n;
  end

  assign rdata = rdata_q;
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[eff_idx] <= eff_wdata;
  end

  // Byte-lane bits only matter when the alignment check is built in.
  logic unused_lsb;
  assign unused_lsb = ^eff_addr[1:0];

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, rready;
  logic [31:0] addr, wdata;
  logic        ready, rvalid, err;
  logic [31:0] rdata;
  logic        req0, we0, rready0;
  logic [31:0] addr0, wdata0;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.AW(10), .WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err), .rready(rready)
  );

  dmem_responder #(.AW(10), .WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0), .rready(rready0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT=2 instance: latency, response values, optional
  // back-pressure stall, and the return to IDLE on the rready edge.
  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_d,
                      input logic exp_e, input int stall);
    int n;
    @(negedge clk);
    chk({tag, "_ready_pre"}, {31'd0, ready}, 32'd1);
    req = 1'b1; we = w; addr = a; wdata = d; rready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    n = 1;
    while (!rvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 32'd3);
    chk({tag, "_rdata"}, rdata, exp_d);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_e});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_rvalid"}, {31'd0, rvalid}, 32'd1);
      chk({tag, "_hold_ready"}, {31'd0, ready}, 32'd0);
      chk({tag, "_hold_rdata"}, rdata, exp_d);
    end
    @(negedge clk);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk({tag, "_done_rvalid"}, {31'd0, rvalid}, 32'd0);
    chk({tag, "_done_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    req = 0; we = 0; addr = 0; wdata = 0; rready = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; rready0 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready0", {31'd0, ready0}, 32'd1);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

    // Write then read; first write is taken on the first edge after reset release.
    xact("wr0",  1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'd0, 1'b0, 0);
    xact("wr10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
    xact("rd10", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);

    // Back-pressure for 5 cycles.
    xact("bp10", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 5);

    // Out of range write must not alias onto word 0.
    xact("oor_wr", 1'b1, 32'h0000_1000, 32'h0000_0001, 32'd0, 1'b1, 0);
    xact("oor_rd", 1'b0, 32'h8000_0004, 32'd0, 32'd0, 1'b1, 0);
    xact("rd0",    1'b0, 32'h0000_0000, 32'd0, 32'hA5A5_0000, 1'b0, 0);

    // Misaligned read.
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    xact("align", 1'b0, 32'h0000_0013, 32'd0, 32'd0, 1'b1, 0);
`else
    xact("align", 1'b0, 32'h0000_0013, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
`endif

    // Reset during WAIT discards the pending write.
    xact("wr20", 1'b1, 32'h0000_0020, 32'h1111_2222, 32'd0, 1'b0, 0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_ready", {31'd0, ready}, 32'd1);
    chk("rstw_rvalid", {31'd0, rvalid}, 32'd0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    xact("rd20", 1'b0, 32'h0000_0020, 32'd0, 32'h1111_2222, 1'b0, 0);

    // Reset during RESP drops the response.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_0010; rready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rstr_pre_rvalid", {31'd0, rvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstr_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rstr_rdata", rdata, 32'd0);
    chk("rstr_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;

    // WAIT=0: req held high, rready held high -> accept every other edge.
    @(negedge clk);
    chk("w0_ready_pre", {31'd0, ready0}, 32'd1);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0040; wdata0 = 32'hCAFE_0001; rready0 = 1'b1;
    @(posedge clk); #1;
    chk("w0_wr_rvalid", {31'd0, rvalid0}, 32'd1);
    chk("w0_wr_err", {31'd0, err0}, 32'd0);
    chk("w0_wr_rdata", rdata0, 32'd0);
    chk("w0_wr_ready", {31'd0, ready0}, 32'd0);
    we0 = 1'b0;
    @(posedge clk); #1;
    chk("w0_idle_rvalid", {31'd0, rvalid0}, 32'd0);
    chk("w0_idle_ready", {31'd0, ready0}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("w0_rd_rvalid", {31'd0, rvalid0}, 32'd1);
      chk("w0_rd_rdata", rdata0, 32'hCAFE_0001);
      chk("w0_rd_ready", {31'd0, ready0}, 32'd0);
      @(posedge clk); #1;
      chk("w0_gap_rvalid", {31'd0, rvalid0}, 32'd0);
      chk("w0_gap_ready", {31'd0, ready0}, 32'd1);
    end
    req0 = 1'b0;
    rready0 = 1'b0;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
